cacheline_burst_adaptor: RTL and testbench
==========================================

Name: cacheline_burst_adaptor

Overview:
- Parametrised bridge between the last-level cache (one full line per request) and a burst-oriented memory port (one BURST_WIDTH beat per resp_i).
- Supports any LINE_WIDTH that is an integer multiple (>=2) of BURST_WIDTH, with a beat counter, line-aligned addressing and an explicit idle/busy FSM.
- An optional watchdog aborts a transfer when memory stalls.
- Sits between the cache datapath and the physical memory model/arbiter.

Parameters:
- LINE_WIDTH, 256, cache line width in bits.
- BURST_WIDTH, 64, memory beat width in bits; BEATS = LINE_WIDTH/BURST_WIDTH.
- ADDR_WIDTH, 32, address width in bits.
- TIMEOUT_CYCLES, 1024, stall limit used only with the optional feature.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- reset_n  in  1  synchronous, active-low reset.
- line_i  in  LINE_WIDTH  write line from LLC.
- line_o  out  LINE_WIDTH  read line to LLC.
- address_i  in  ADDR_WIDTH  request address.
- read_i  in  1  LLC read request, level, held until resp_o.
- write_i  in  1  LLC write request, level, held until resp_o.
- resp_o  out  1  one-cycle completion pulse.
- err_o  out  1  one-cycle abort pulse (timeout).
- burst_i  in  BURST_WIDTH  read beat from memory.
- burst_o  out  BURST_WIDTH  write beat to memory.
- address_o  out  ADDR_WIDTH  line-aligned memory address.
- read_o  out  1  memory read request.
- write_o  out  1  memory write request.
- resp_i  in  1  memory per-beat acknowledge.

Behaviour:
- Reset (reset_n=0 at a clk edge) forces state IDLE, beat_cnt=0, read_o=0, write_o=0, resp_o=0, err_o=0, address_o=0, burst_o=0, line_o=0.
- Reset overrides everything, including a transfer in progress. No response is issued for an aborted transfer.
- States: IDLE, RD_BURST, WR_BURST, DONE.
- IDLE:
  - read_i=1: latch address_o = address_i with the low log2(LINE_WIDTH/8) bits cleared; read_o<=1; beat_cnt<=0; go to RD_BURST.
  - write_i=1 (and read_i=0): latch line_i into the write buffer; latch the aligned address; write_o<=1; burst_o<=line_i[BURST_WIDTH-1:0]; go to WR_BURST.
  - Both asserted: read wins; write_i is re-sampled after completion.
- RD_BURST:
  - Each cycle with resp_i=1 stores burst_i into line_o beat slot beat_cnt (beat k = bits [k*BURST_WIDTH +: BURST_WIDTH]) and increments beat_cnt.
  - resp_i=0 means hold; any number of stall cycles is legal.
  - On the beat with beat_cnt==BEATS-1: read_o<=0, resp_o<=1, go to DONE.
- WR_BURST:
  - Each resp_i=1 advances beat_cnt and sets burst_o to the next buffered beat.
  - On the final beat: write_o<=0, resp_o<=1, go to DONE.
  - burst_o is stable while resp_i=0.
- DONE: lasts one cycle. resp_o<=0, beat_cnt<=0, go to IDLE. read_i/write_i are ignored in this cycle.
- Requests asserted while not IDLE are ignored; line_i and address_i changes mid-transfer have no effect.
- line_o holds its value after resp_o until the next read's first beat. For the write path, line_o is never modified.
- Latency with zero stalls:
  - Request sampled at edge 0; read_o/write_o high from edge 0.
  - Final beat accepted at edge BEATS; resp_o high for the cycle after edge BEATS.
  - Next request can be sampled at edge BEATS+2.
- resp_i while IDLE or DONE is ignored.

Optional Feature:
- Macro: CL_ADAPTOR_TIMEOUT_EN.
- Defined:
  - A stall counter resets on every resp_i=1 and on entry to RD_BURST/WR_BURST.
  - When it reaches TIMEOUT_CYCLES consecutive cycles without resp_i: read_o/write_o<=0, err_o<=1 and resp_o<=1 for one cycle, go to DONE.
  - line_o contents are undefined after a read timeout.
- Not defined: no counter; err_o is tied to 0; transfers wait for resp_i indefinitely.

Test Plan:
- Read, defaults, address_i=0x0000_1234, beats 0x11..,0x22..,0x33..,0x44.. with no stalls -> address_o=0x0000_1220; resp_o pulses 1 cycle after the 4th beat; line_o = {0x44..,0x33..,0x22..,0x11..}.
- Write, line_i = {D3,D2,D1,D0}, resp_i with a 3-cycle stall before beat 2 -> burst_o sequence D0,D1,D1(held),D1,D1,D2,D3; write_o drops after D3 is accepted; one resp_o pulse.
- read_i and write_i asserted together -> read executes first, write starts only after DONE; two resp_o pulses in total.
- LINE_WIDTH=512, BURST_WIDTH=128 -> 4 beats assembled correctly; address low 6 bits cleared.
- reset_n=0 during beat 2 of a read -> next cycle read_o=0, resp_o=0, state IDLE; a following read completes normally.
- CL_ADAPTOR_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, resp_i never asserted -> after 16 cycles err_o=1 and resp_o=1 for exactly 1 cycle; read_o=0.

Source files
------------

// File: rtl/cacheline_burst_adaptor.sv
// Bridges full cache-line requests from the LLC onto a beat-by-beat memory burst port.
// Optional stall watchdog: define CL_ADAPTOR_TIMEOUT_EN to abort transfers after TIMEOUT_CYCLES idle beats.
module cacheline_burst_adaptor #(
    parameter int LINE_WIDTH     = 256,
    parameter int BURST_WIDTH    = 64,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [LINE_WIDTH-1:0] line_i,
    output logic [LINE_WIDTH-1:0] line_o,
    input  logic [ADDR_WIDTH-1:0] address_i,
    input  logic                  read_i,
    input  logic                  write_i,
    output logic                  resp_o,
    output logic                  err_o,
    input  logic [BURST_WIDTH-1:0] burst_i,
    output logic [BURST_WIDTH-1:0] burst_o,
    output logic [ADDR_WIDTH-1:0] address_o,
    output logic                  read_o,
    output logic                  write_o,
    input  logic                  resp_i
);

    localparam int BEATS = LINE_WIDTH / BURST_WIDTH;
    localparam int CNT_W = $clog2(BEATS);
    localparam int OFFS  = $clog2(LINE_WIDTH / 8);
    localparam logic [CNT_W-1:0]      LAST_BEAT  = CNT_W'(BEATS - 1);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {ADDR_WIDTH{1'b1}} << OFFS;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_BURST = 2'd1,
        WR_BURST = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        beat_cnt_q, beat_cnt_d;
    logic [CNT_W-1:0]        beat_nxt;
    logic                    read_q, read_d;
    logic                    write_q, write_d;
    logic                    resp_q, resp_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [BURST_WIDTH-1:0]  burst_q, burst_d;
    logic [LINE_WIDTH-1:0]   line_q, line_d;
    logic [LINE_WIDTH-1:0]   wbuf_q, wbuf_d;

`ifdef CL_ADAPTOR_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT_CYCLES - 1);
    logic [STALL_W-1:0]      stall_q, stall_d;
    logic                    err_q, err_d;
`endif

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        beat_nxt   = beat_cnt_q + 1'b1;
        read_d     = read_q;
        write_d    = write_q;
        resp_d     = 1'b0;
        addr_d     = addr_q;
        burst_d    = burst_q;
        line_d     = line_q;
        wbuf_d     = wbuf_q;
`ifdef CL_ADAPTOR_TIMEOUT_EN
        stall_d    = '0;
        err_d      = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                // Read has priority; a concurrent write stays pending on write_i.
                if (read_i) begin
                    addr_d     = address_i & ALIGN_MASK;
                    read_d     = 1'b1;
                    beat_cnt_d = '0;
                    state_d    = RD_BURST;
                end else if (write_i) begin
                    wbuf_d     = line_i;
                    addr_d     = address_i & ALIGN_MASK;
                    write_d    = 1'b1;
                    burst_d    = line_i[BURST_WIDTH-1:0];
                    beat_cnt_d = '0;
                    state_d    = WR_BURST;
                end
            end
            RD_BURST: begin
                if (resp_i) begin
                    line_d[int'(beat_cnt_q)*BURST_WIDTH +: BURST_WIDTH] = burst_i;
                    beat_cnt_d = beat_nxt;
                    if (beat_cnt_q == LAST_BEAT) begin
                        read_d  = 1'b0;
                        resp_d  = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            WR_BURST: begin
                if (resp_i) begin
                    beat_cnt_d = beat_nxt;
                    if (beat_cnt_q == LAST_BEAT) begin
                        write_d = 1'b0;
                        resp_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        burst_d = wbuf_q[int'(beat_nxt)*BURST_WIDTH +: BURST_WIDTH];
                    end
                end
            end
            DONE: begin
                beat_cnt_d = '0;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
`ifdef CL_ADAPTOR_TIMEOUT_EN
        // Counter is zero outside bursts, so entering a burst starts it fresh.
        if ((state_q == RD_BURST || state_q == WR_BURST) && !resp_i) begin
            if (stall_q == STALL_LAST) begin
                read_d  = 1'b0;
                write_d = 1'b0;
                resp_d  = 1'b1;
                err_d   = 1'b1;
                state_d = DONE;
            end else begin
                stall_d = stall_q + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            beat_cnt_q <= '0;
            read_q     <= 1'b0;
            write_q    <= 1'b0;
            resp_q     <= 1'b0;
            addr_q     <= '0;
            burst_q    <= '0;
            line_q     <= '0;
            wbuf_q     <= '0;
`ifdef CL_ADAPTOR_TIMEOUT_EN
            stall_q    <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            read_q     <= read_d;
            write_q    <= write_d;
            resp_q     <= resp_d;
            addr_q     <= addr_d;
            burst_q    <= burst_d;
            line_q     <= line_d;
            wbuf_q     <= wbuf_d;
`ifdef CL_ADAPTOR_TIMEOUT_EN
            stall_q    <= stall_d;
            err_q      <= err_d;
`endif
        end
    end

    assign line_o    = line_q;
    assign resp_o    = resp_q;
    assign burst_o   = burst_q;
    assign address_o = addr_q;
    assign read_o    = read_q;
    assign write_o   = write_q;
`ifdef CL_ADAPTOR_TIMEOUT_EN
    assign err_o     = err_q;
`else
    assign err_o     = 1'b0;
`endif

endmodule

// File: tb/tb_cacheline_burst_adaptor.sv
// Randomised bench for cacheline_burst_adaptor: a default 256/64 instance and a 512/128 instance,
// checked against a line/beat model built from plain arithmetic.
module tb_cacheline_burst_adaptor;

    localparam int LW = 256, BW = 64, AW = 32, BEATS = LW / BW, TO = 16;
    localparam int WLW = 512, WBW = 128, WBEATS = WLW / WBW;

    // Clock / reset
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic [LW-1:0] line_i, line_o;
    logic [AW-1:0] address_i, address_o;
    logic          read_i, write_i, resp_o, err_o, read_o, write_o, resp_i;
    logic [BW-1:0] burst_i, burst_o;

    logic [WLW-1:0] w_line_i, w_line_o;
    logic [AW-1:0]  w_address_i, w_address_o;
    logic           w_read_i, w_write_i, w_resp_o, w_err_o, w_read_o, w_write_o, w_resp_i;
    logic [WBW-1:0] w_burst_i, w_burst_o;

    cacheline_burst_adaptor #(.LINE_WIDTH(LW), .BURST_WIDTH(BW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) u_dut (
        .clk(clk), .reset_n(reset_n), .line_i(line_i), .line_o(line_o), .address_i(address_i),
        .read_i(read_i), .write_i(write_i), .resp_o(resp_o), .err_o(err_o), .burst_i(burst_i),
        .burst_o(burst_o), .address_o(address_o), .read_o(read_o), .write_o(write_o), .resp_i(resp_i)
    );

    cacheline_burst_adaptor #(.LINE_WIDTH(WLW), .BURST_WIDTH(WBW), .ADDR_WIDTH(AW)) u_wide (
        .clk(clk), .reset_n(reset_n), .line_i(w_line_i), .line_o(w_line_o), .address_i(w_address_i),
        .read_i(w_read_i), .write_i(w_write_i), .resp_o(w_resp_o), .err_o(w_err_o), .burst_i(w_burst_i),
        .burst_o(w_burst_o), .address_o(w_address_o), .read_o(w_read_o), .write_o(w_write_o), .resp_i(w_resp_i)
    );

    // Scoreboard state
    int n_tests = 0;
    int n_fail  = 0;
    logic [BW-1:0] exp_q[$];
    logic [LW-1:0] model_line;
    bit            model_line_valid;

    function automatic logic [AW-1:0] align(input logic [AW-1:0] a, input int line_bits);
        int unsigned bytes;
        bytes = line_bits / 8;
        return a / bytes * bytes;
    endfunction

    function automatic logic [BW-1:0] rand_beat();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] l;
        for (int k = 0; k < BEATS; k++) l[k*BW +: BW] = rand_beat();
        return l;
    endfunction

    // Driver tasks
    task automatic start_read(input logic [AW-1:0] addr);
        read_i = 1'b1;
        address_i = addr;
        @(posedge clk); #1;
        n_tests++;
        if (read_o !== 1'b1 || write_o !== 1'b0 || address_o !== align(addr, LW)) begin
            n_fail++;
            $display("FAIL start_read: read_o=%b write_o=%b address_o=%h, required 1/0/%h", read_o, write_o, address_o, align(addr, LW));
        end
        address_i = $urandom;
        line_i = rand_line();
    endtask

    task automatic read_beats(input int max_stall, input int stall_k, input int stall_n);
        logic [LW-1:0] exp_line;
        logic [BW-1:0] beat;
        int s;
        exp_line = model_line;
        for (int k = 0; k < BEATS; k++) begin
            s = (k == stall_k) ? stall_n : int'($urandom_range(0, max_stall));
            for (int j = 0; j < s; j++) begin
                resp_i = 1'b0;
                burst_i = rand_beat();
                @(posedge clk); #1;
                n_tests++;
                if (read_o !== 1'b1 || resp_o !== 1'b0) begin
                    n_fail++;
                    $display("FAIL read_stall: read_o=%b resp_o=%b, required 1/0", read_o, resp_o);
                end
            end
            beat = rand_beat();
            exp_line[k*BW +: BW] = beat;
            resp_i = 1'b1;
            burst_i = beat;
            @(posedge clk); #1;
            if (k < BEATS - 1) begin
                n_tests++;
                if (resp_o !== 1'b0 || read_o !== 1'b1) begin
                    n_fail++;
                    $display("FAIL read_mid: beat %0d resp_o=%b read_o=%b, required 0/1", k, resp_o, read_o);
                end
            end
        end
        resp_i = 1'b0;
        read_i = 1'b0;
        model_line = exp_line;
        model_line_valid = 1'b1;
        n_tests++;
        if (resp_o !== 1'b1 || read_o !== 1'b0 || err_o !== 1'b0 || line_o !== exp_line) begin
            n_fail++;
            $display("FAIL read_done: resp_o=%b read_o=%b err_o=%b line_o=%h, required 1/0/0/%h", resp_o, read_o, err_o, line_o, exp_line);
        end
        resp_i = 1'b1;  // acknowledges in DONE must be ignored
        @(posedge clk); #1;
        resp_i = 1'b0;
        n_tests++;
        if (resp_o !== 1'b0 || read_o !== 1'b0 || line_o !== exp_line) begin
            n_fail++;
            $display("FAIL read_after: resp_o=%b read_o=%b line_o=%h, required 0/0/%h", resp_o, read_o, line_o, exp_line);
        end
    endtask

    task automatic start_write(input logic [LW-1:0] line, input logic [AW-1:0] addr);
        write_i = 1'b1;
        line_i = line;
        address_i = addr;
        exp_q.delete();
        for (int k = 0; k < BEATS; k++) exp_q.push_back(line[k*BW +: BW]);
        @(posedge clk); #1;
        n_tests++;
        if (write_o !== 1'b1 || read_o !== 1'b0 || address_o !== align(addr, LW)) begin
            n_fail++;
            $display("FAIL start_write: write_o=%b read_o=%b address_o=%h, required 1/0/%h", write_o, read_o, address_o, align(addr, LW));
        end
        line_i = rand_line();
        address_i = $urandom;
    endtask

    task automatic write_beats(input int max_stall, input int stall_k, input int stall_n);
        int s;
        for (int k = 0; k < BEATS; k++) begin
            s = (k == stall_k) ? stall_n : int'($urandom_range(0, max_stall));
            for (int j = 0; j < s; j++) begin
                n_tests++;
                if (burst_o !== exp_q[0] || write_o !== 1'b1 || resp_o !== 1'b0) begin
                    n_fail++;
                    $display("FAIL write_stall: beat %0d burst_o=%h write_o=%b resp_o=%b, required %h/1/0", k, burst_o, write_o, resp_o, exp_q[0]);
                end
                resp_i = 1'b0;
                @(posedge clk); #1;
            end
            n_tests++;
            if (burst_o !== exp_q[0] || write_o !== 1'b1 || resp_o !== 1'b0) begin
                n_fail++;
                $display("FAIL write_beat: beat %0d burst_o=%h write_o=%b resp_o=%b, required %h/1/0", k, burst_o, write_o, resp_o, exp_q[0]);
            end
            resp_i = 1'b1;
            @(posedge clk); #1;
            void'(exp_q.pop_front());
        end
        resp_i = 1'b0;
        write_i = 1'b0;
        n_tests++;
        if (resp_o !== 1'b1 || write_o !== 1'b0 || err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL write_done: resp_o=%b write_o=%b err_o=%b, required 1/0/0", resp_o, write_o, err_o);
        end
        if (model_line_valid) begin
            n_tests++;
            if (line_o !== model_line) begin
                n_fail++;
                $display("FAIL write_line_o: line_o=%h, required %h", line_o, model_line);
            end
        end
        @(posedge clk); #1;
        n_tests++;
        if (resp_o !== 1'b0 || write_o !== 1'b0) begin
            n_fail++;
            $display("FAIL write_after: resp_o=%b write_o=%b, required 0/0", resp_o, write_o);
        end
    endtask

    // Scenarios
    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (read_o !== 1'b0 || write_o !== 1'b0 || resp_o !== 1'b0 || err_o !== 1'b0 ||
            address_o !== '0 || burst_o !== '0 || line_o !== '0) begin
            n_fail++;
            $display("FAIL reset: rd=%b wr=%b resp=%b err=%b addr=%h burst=%h line=%h, required all zero",
                     read_o, write_o, resp_o, err_o, address_o, burst_o, line_o);
        end
        n_tests++;
        if (w_read_o !== 1'b0 || w_resp_o !== 1'b0 || w_address_o !== '0 || w_line_o !== '0) begin
            n_fail++;
            $display("FAIL reset_wide: rd=%b resp=%b addr=%h line=%h, required all zero", w_read_o, w_resp_o, w_address_o, w_line_o);
        end
        reset_n = 1'b1;
        model_line = '0;
        model_line_valid = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_read();
        start_read(32'h0000_1234);
        n_tests++;
        if (address_o !== 32'h0000_1220) begin
            n_fail++;
            $display("FAIL read_addr: address_o=%h, required 00001220", address_o);
        end
        read_beats(0, -1, 0);
    endtask

    task automatic test_write();
        start_write(rand_line(), $urandom);
        write_beats(0, 1, 3);
    endtask

    task automatic test_both();
        logic [LW-1:0] wl;
        logic [AW-1:0] wa;
        wl = rand_line();
        wa = $urandom;
        write_i = 1'b1;
        line_i = wl;
        start_read($urandom);
        read_beats(1, -1, 0);
        n_tests++;
        if (write_o !== 1'b0) begin
            n_fail++;
            $display("FAIL both_order: write_o=%b before write start, required 0", write_o);
        end
        start_write(wl, wa);
        write_beats(1, -1, 0);
    endtask

    task automatic test_reset_mid();
        start_read($urandom);
        for (int k = 0; k < 2; k++) begin
            resp_i = 1'b1;
            burst_i = rand_beat();
            @(posedge clk); #1;
        end
        resp_i = 1'b1;
        burst_i = rand_beat();
        reset_n = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if (read_o !== 1'b0 || resp_o !== 1'b0 || line_o !== '0 || address_o !== '0 || err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: read_o=%b resp_o=%b line_o=%h address_o=%h err_o=%b, required zeros",
                     read_o, resp_o, line_o, address_o, err_o);
        end
        reset_n = 1'b1;
        read_i = 1'b0;
        resp_i = 1'b0;
        model_line = '0;
        model_line_valid = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (resp_o !== 1'b0 || read_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_after: resp_o=%b read_o=%b, required 0/0", resp_o, read_o);
        end
        start_read($urandom);
        read_beats(2, -1, 0);
    endtask

    task automatic test_random_rw();
        for (int t = 0; t < 16; t++) begin
            if ($urandom_range(0, 1) == 1) begin
                resp_i = 1'b1;  // a stray acknowledge in IDLE must not start anything
                @(posedge clk); #1;
                resp_i = 1'b0;
                n_tests++;
                if (read_o !== 1'b0 || write_o !== 1'b0 || resp_o !== 1'b0) begin
                    n_fail++;
                    $display("FAIL idle_resp: read_o=%b write_o=%b resp_o=%b, required 0/0/0", read_o, write_o, resp_o);
                end
            end
            if ($urandom_range(0, 1) == 1) begin
                start_read($urandom);
                read_beats(3, -1, 0);
            end else begin
                start_write(rand_line(), $urandom);
                write_beats(3, -1, 0);
            end
        end
    endtask

    task automatic test_wide();
        logic [WLW-1:0] exp_line;
        logic [WBW-1:0] beat;
        logic [AW-1:0]  addr;
        addr = $urandom;
        exp_line = '0;
        w_read_i = 1'b1;
        w_address_i = addr;
        @(posedge clk); #1;
        n_tests++;
        if (w_read_o !== 1'b1 || w_address_o !== align(addr, WLW) || w_address_o[5:0] !== 6'd0) begin
            n_fail++;
            $display("FAIL wide_start: read_o=%b address_o=%h, required 1/%h", w_read_o, w_address_o, align(addr, WLW));
        end
        for (int k = 0; k < WBEATS; k++) begin
            repeat ($urandom_range(0, 2)) begin
                w_resp_i = 1'b0;
                @(posedge clk); #1;
            end
            beat = {$urandom, $urandom, $urandom, $urandom};
            exp_line[k*WBW +: WBW] = beat;
            w_burst_i = beat;
            w_resp_i = 1'b1;
            @(posedge clk); #1;
        end
        w_resp_i = 1'b0;
        w_read_i = 1'b0;
        n_tests++;
        if (w_resp_o !== 1'b1 || w_read_o !== 1'b0 || w_line_o !== exp_line) begin
            n_fail++;
            $display("FAIL wide_done: resp_o=%b read_o=%b line_o=%h, required 1/0/%h", w_resp_o, w_read_o, w_line_o, exp_line);
        end
        @(posedge clk); #1;
        n_tests++;
        if (w_resp_o !== 1'b0) begin
            n_fail++;
            $display("FAIL wide_after: resp_o=%b, required 0", w_resp_o);
        end
    endtask

`ifdef CL_ADAPTOR_TIMEOUT_EN
    task automatic test_timeout();
        start_read($urandom);
        resp_i = 1'b0;
        for (int c = 1; c < TO; c++) begin
            @(posedge clk); #1;
            n_tests++;
            if (err_o !== 1'b0 || resp_o !== 1'b0 || read_o !== 1'b1) begin
                n_fail++;
                $display("FAIL timeout_early: cycle %0d err_o=%b resp_o=%b read_o=%b, required 0/0/1", c, err_o, resp_o, read_o);
            end
        end
        @(posedge clk); #1;
        read_i = 1'b0;
        model_line_valid = 1'b0;
        n_tests++;
        if (err_o !== 1'b1 || resp_o !== 1'b1 || read_o !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_fire: err_o=%b resp_o=%b read_o=%b, required 1/1/0", err_o, resp_o, read_o);
        end
        @(posedge clk); #1;
        n_tests++;
        if (err_o !== 1'b0 || resp_o !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_after: err_o=%b resp_o=%b, required 0/0", err_o, resp_o);
        end
        start_write(rand_line(), $urandom);
        write_beats(1, -1, 0);
    endtask
`endif

    initial begin
        read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
        line_i = '0; address_i = '0; burst_i = '0;
        w_read_i = 1'b0; w_write_i = 1'b0; w_resp_i = 1'b0;
        w_line_i = '0; w_address_i = '0; w_burst_i = '0;
        model_line = '0;
        model_line_valid = 1'b1;
        test_reset();
        test_read();
        test_write();
        test_both();
        test_reset_mid();
        test_random_rw();
        test_wide();
`ifdef CL_ADAPTOR_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
